// File: rtl/barrier_core_frontend.sv
// rtl/barrier_core_frontend.sv - per-cluster barrier front-end: arrival serializer and core release.
// Optional per-core clock gating during WAIT is enabled by defining BARRIER_CLKGATE_EN.
module barrier_core_frontend #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_CORES-1:0] core_req_i,
  output logic [NUM_CORES-1:0] core_ack_o,
  output logic [NUM_CORES-1:0] core_busy_o,
  output logic [NUM_CORES-1:0] core_clk_en_o,
  output logic [NUM_CORES-1:0] core_abort_o,
  output logic                 barrier_get_o,
  input  logic [NUM_CORES-1:0] barrier_event_i,
  input  logic                 flush_i,
  output logic                 clear_req_o,
  output logic                 spurious_evt_o,
  input  logic                 spurious_clr_i
);

  localparam int PW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT, S_REL} state_e;

  state_e               state_q [NUM_CORES];
  state_e               state_d [NUM_CORES];
  logic [NUM_CORES-1:0] pend;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [NUM_CORES-1:0] abort_q, abort_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        cand;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_vld;
  logic                 clear_q;
  logic                 spur_q;
  logic                 spur_set;

  always_comb begin
    pend        = '0;
    core_busy_o = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      pend[k]        = (state_q[k] == S_PEND);
      core_busy_o[k] = (state_q[k] == S_PEND) || (state_q[k] == S_WAIT);
    end
  end

  // Round-robin: first pending core at or after the pointer wins; flush blocks all grants.
  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = ptr_q + PW'(i);
      if (!gnt_vld && pend[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (flush_i) begin
      gnt_vld = 1'b0;
    end
    ptr_d = gnt_vld ? gnt_idx + PW'(1) : ptr_q;
  end

  always_comb begin
    spur_set = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      state_d[k] = state_q[k];
      ack_d[k]   = 1'b0;
      abort_d[k] = 1'b0;
      if (barrier_event_i[k] && (state_q[k] != S_WAIT)) begin
        spur_set = 1'b1;
      end
      case (state_q[k])
        S_IDLE: begin
          if (core_req_i[k]) state_d[k] = S_PEND;
        end
        S_PEND: begin
          if (flush_i) begin
            state_d[k] = S_REL;
            ack_d[k]   = 1'b1;
            abort_d[k] = 1'b1;
          end else if (gnt_vld && (gnt_idx == PW'(k))) begin
            state_d[k] = S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            state_d[k] = S_REL;
            ack_d[k]   = 1'b1;
            abort_d[k] = 1'b1;
          end else if (barrier_event_i[k]) begin
            state_d[k] = S_REL;
            ack_d[k]   = 1'b1;
          end
        end
        S_REL: begin
          if (!core_req_i[k]) state_d[k] = S_IDLE;
        end
        default: state_d[k] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CORES; k++) state_q[k] <= S_IDLE;
      ack_q   <= '0;
      abort_q <= '0;
      ptr_q   <= '0;
      clear_q <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) state_q[k] <= state_d[k];
      ack_q   <= ack_d;
      abort_q <= abort_d;
      ptr_q   <= ptr_d;
      clear_q <= flush_i;
      // A new spurious event takes priority over a simultaneous clear.
      if (spur_set) spur_q <= 1'b1;
      else if (spurious_clr_i) spur_q <= 1'b0;
    end
  end

`ifdef BARRIER_CLKGATE_EN
  logic [NUM_CORES-1:0] clk_en_q;

  // Registered from next state so the enable is clean and already high in the ack cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_en_q <= '1;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) clk_en_q[k] <= (state_d[k] != S_WAIT);
    end
  end

  assign core_clk_en_o = clk_en_q;
`else
  assign core_clk_en_o = '1;
`endif

  assign core_ack_o     = ack_q;
  assign core_abort_o   = abort_q;
  assign barrier_get_o  = (|pend) && !flush_i;
  assign clear_req_o    = clear_q;
  assign spurious_evt_o = spur_q;

endmodule

// File: tb/tb_barrier_core_frontend.sv
// tb/tb_barrier_core_frontend.sv - directed testbench for barrier_core_frontend.
module tb_barrier_core_frontend;

`ifdef BARRIER_CLKGATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, evt;
  logic       flush, sclr;
  logic [3:0] ack, busy, clk_en, abort;
  logic       get, clr, spur;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  barrier_core_frontend #(.NUM_CORES(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .core_req_i     (req),
    .core_ack_o     (ack),
    .core_busy_o    (busy),
    .core_clk_en_o  (clk_en),
    .core_abort_o   (abort),
    .barrier_get_o  (get),
    .barrier_event_i(evt),
    .flush_i        (flush),
    .clear_req_o    (clr),
    .spurious_evt_o (spur),
    .spurious_clr_i (sclr)
  );

  // Expected clock enables given the set of cores in WAIT.
  function automatic logic [3:0] ce(input logic [3:0] waiting);
    return GATE ? ~waiting : 4'hf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [3:0] e_ack, input logic [3:0] e_busy,
                      input logic [3:0] e_ce, input logic [3:0] e_abort, input logic e_get,
                      input logic e_clr, input logic e_spur);
    chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".clk_en"}, 32'(clk_en), 32'(e_ce));
    chk({tag, ".abort"}, 32'(abort), 32'(e_abort));
    chk({tag, ".get"}, 32'(get), 32'(e_get));
    chk({tag, ".clear"}, 32'(clr), 32'(e_clr));
    chk({tag, ".spur"}, 32'(spur), 32'(e_spur));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; evt = '0; flush = 1'b0; sclr = 1'b0;
    repeat (2) cyc();
    outs("reset", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // all four cores at once, pointer 0: grants 0,1,2,3 on consecutive cycles
    cyc(); req = 4'hf; #1; outs("all_c0", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); #1; outs("all_c1", 4'h0, 4'hf, 4'hf, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); #1; outs("all_c2", 4'h0, 4'hf, ce(4'h1), 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); #1; outs("all_c3", 4'h0, 4'hf, ce(4'h3), 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); #1; outs("all_c4", 4'h0, 4'hf, ce(4'h7), 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); evt = 4'hf; #1; outs("all_c5", 4'h0, 4'hf, ce(4'hf), 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); evt = 4'h0; #1; outs("all_c6", 4'hf, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); req = 4'h0; #1; outs("all_c7", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc();

    // single core 0, pointer back at 0
    cyc(); req = 4'h1; #1; outs("one_c0", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); #1; outs("one_c1", 4'h0, 4'h1, 4'hf, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); evt = 4'h1; #1; outs("one_c2", 4'h0, 4'h1, ce(4'h1), 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); evt = 4'h0; #1; outs("one_c3", 4'h1, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); #1; outs("one_c4", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    req = 4'h0;
    cyc();

    // staggered: core 2 at cycle 0, core 1 at cycle 10, 2-thread barrier
    cyc(); req = 4'h4;
    cyc(); #1; outs("stg_c1", 4'h0, 4'h4, 4'hf, 4'h0, 1'b1, 1'b0, 1'b0);
    repeat (8) cyc();
    #1; outs("stg_c9", 4'h0, 4'h4, ce(4'h4), 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); req = 4'h6; #1; outs("stg_c10", 4'h0, 4'h4, ce(4'h4), 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); #1; outs("stg_c11", 4'h0, 4'h6, ce(4'h4), 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); evt = 4'h6; #1; outs("stg_c12", 4'h0, 4'h6, ce(4'h6), 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); evt = 4'h0; #1; outs("stg_c13", 4'h6, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    req = 4'h0;
    cyc();

    // pointer now 2: cores 1 and 2 together must grant 2 before 1
    cyc(); req = 4'h6;
    cyc(); #1; outs("ord_c1", 4'h0, 4'h6, 4'hf, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); evt = 4'h4; #1; outs("ord_c2", 4'h0, 4'h6, ce(4'h4), 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); evt = 4'h2; #1; outs("ord_c3", 4'h4, 4'h2, ce(4'h2), 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); evt = 4'h0; #1; outs("ord_c4", 4'h2, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    req = 4'h0;
    cyc();

    // flush with cores 0 and 3 in WAIT (pointer 2: grant 3 then 0)
    cyc(); req = 4'h9;
    cyc(); #1; outs("fl_c1", 4'h0, 4'h9, 4'hf, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); #1; outs("fl_c2", 4'h0, 4'h9, ce(4'h8), 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); flush = 1'b1; #1; outs("fl_c3", 4'h0, 4'h9, ce(4'h9), 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); flush = 1'b0; #1; outs("fl_c4", 4'h9, 4'h0, 4'hf, 4'h9, 1'b0, 1'b1, 1'b0);
    cyc(); req = 4'h0; #1; outs("fl_c5", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc();

    // flush while core 1 is pending: get forced low, no grant, aborted release
    cyc(); req = 4'h2;
    cyc(); #1; outs("flp_c1", 4'h0, 4'h2, 4'hf, 4'h0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1; #1; chk("flp_get_forced", 32'(get), 32'd0);
    cyc(); flush = 1'b0; #1; outs("flp_c2", 4'h2, 4'h0, 4'hf, 4'h2, 1'b0, 1'b1, 1'b0);
    cyc(); req = 4'h0; #1; outs("flp_c3", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc();

    // spurious event on idle core 2, sticky, clear, and set-beats-clear
    evt = 4'h4; #1; outs("sp_c0", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); evt = 4'h0; #1; outs("sp_c1", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(); #1; outs("sp_c2", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b1);
    sclr = 1'b1;
    cyc(); sclr = 1'b0; #1; outs("sp_clr", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    evt = 4'h4; sclr = 1'b1;
    cyc(); evt = 4'h0; sclr = 1'b0; #1; outs("sp_setwin", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b1);
    sclr = 1'b1;
    cyc(); sclr = 1'b0; #1; chk("sp_clr2", 32'(spur), 32'd0);

    // reset while cores 0 and 1 wait (pointer 1: grant 1 then 0)
    cyc(); req = 4'h3;
    cyc(); #1; outs("rst_c1", 4'h0, 4'h3, 4'hf, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); #1; outs("rst_c2", 4'h0, 4'h3, ce(4'h2), 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); #1; outs("rst_c3", 4'h0, 4'h3, ce(4'h3), 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; req = 4'h0; #1;
    outs("rst_assert", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); evt = 4'h3; #1; outs("rst_hold", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    evt = 4'h0; rst_n = 1'b1;
    cyc(); #1; outs("rst_post1", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(); #1; outs("rst_post2", 4'h0, 4'h0, 4'hf, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrier_core_frontend.md
# barrier_core_frontend

Per-cluster front-end for the hardware barrier counter. It collects barrier-arrival requests from up to NUM_CORES cores, which may arrive simultaneously. It serializes them into single-cycle arrival pulses toward the barrier counter/mask logic, holds each arrived core in a wait state, and releases it when its bit of the barrier event vector fires. It sits between the cores' event-unit register port and the barrier counter, and is the initiator side of the barrier_get / barrier_event protocol.

## Interface
Parameters:
- NUM_CORES, default 4: number of cores served; ≥2, power of two.

Ports:
- clk_i  input  1  cluster clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- core_req_i  input  NUM_CORES  per-core level barrier request; held until ack.
- core_ack_o  output  NUM_CORES  per-core one-cycle release pulse.
- core_busy_o  output  NUM_CORES  core is pending or waiting (stall qualifier).
- core_clk_en_o  output  NUM_CORES  per-core clock enable (see Configuration).
- core_abort_o  output  NUM_CORES  qualifies core_ack_o: release was caused by flush.
- barrier_get_o  output  1  one arrival pulse to the counter per cycle, max.
- barrier_event_i  input  NUM_CORES  release vector from the counter logic.
- flush_i  input  1  synchronous abort of the current barrier.
- clear_req_o  output  1  counter clear request to the counter logic.
- spurious_evt_o  output  1  sticky: an event bit hit a core not in WAIT.
- spurious_clr_i  input  1  clears spurious_evt_o.

## Operation
- Per-core FSM: IDLE, PEND, WAIT, REL.
  - IDLE→PEND when core_req_i[k]=1.
  - PEND→WAIT when granted.
  - WAIT→REL when barrier_event_i[k]=1.
  - REL: core_ack_o[k]=1 for exactly one cycle (first REL cycle), then stay in REL until core_req_i[k]=0, then →IDLE.
- Arbiter: round-robin over PEND cores; the pointer advances to grant+1 after each grant.
  - barrier_get_o = OR of PEND bits (combinational).
  - The granted core moves to WAIT at the same edge the counter increments.
- core_busy_o[k]=1 in PEND and WAIT; 0 in IDLE and REL.
- barrier_event_i bits for cores in IDLE, PEND or REL are ignored for state, and set spurious_evt_o.
  - If spurious_clr_i and a new spurious event coincide, the set wins.
- flush_i=1 (sampled at an edge):
  - all PEND and WAIT cores go to REL with core_abort_o[k]=1 alongside their ack pulse;
  - clear_req_o=1 in the following cycle, one cycle wide;
  - no grant that cycle; barrier_get_o is forced 0 while flush_i=1.
- A core whose req stays high after leaving REL re-enters only via IDLE; it needs at least one low cycle.
- Reset: all FSMs IDLE, arbiter pointer 0, and every output at its reset value. Reset values: core_ack_o=0, core_busy_o=0, core_clk_en_o=all 1, core_abort_o=0, barrier_get_o=0, clear_req_o=0, spurious_evt_o=0. Reset mid-barrier drops all waiting cores without ack.

## Timing
- req rises in cycle 0 → PEND in cycle 1 → barrier_get_o=1 in cycle 1 if granted → WAIT in cycle 2.
- For the last arrival, the counter's event appears combinationally in cycle 2 → REL and core_ack_o in cycle 3. Best-case request-to-ack is 3 cycles.
- N simultaneous requests need N consecutive barrier_get_o cycles. The k-th granted core (k from 0) enters WAIT at cycle 2+k.
- An event and a grant for different cores in the same cycle are both honoured.
- Flush in cycle t → ack/abort in t+1, clear_req_o in t+1.

## Configuration
- BARRIER_CLKGATE_EN defined: core_clk_en_o[k]=0 while core k is in WAIT. It returns to 1 in the REL cycle, registered, glitch-free, so the ack cycle is clocked.
- Without it: core_clk_en_o is constant all-ones; behaviour is otherwise identical.

## Test plan
- Single core, NUM_CORES=4, counter set to 1 thread, mask 0001. core 0 req at cycle 0 → get at cycle 1, ack[0] at cycle 3, busy[0] high in cycles 1-2.
- All 4 cores req in the same cycle, 4 threads, mask 1111. Required response:
  - get high 4 consecutive cycles;
  - grant order 0,1,2,3 from pointer 0;
  - all four ack in the same cycle.
- Staggered arrivals (core 2 at cycle 0, core 1 at cycle 10) with a 2-thread barrier → ack[2] and ack[1] in the same cycle, 3 cycles after core 1 req. Next round's grant order starts after the last-granted core.
- Flush while cores 0 and 3 are in WAIT → ack and abort on bits 0 and 3 the next cycle, clear_req_o one pulse, no get.
- Event bit 2 while core 2 is IDLE → spurious_evt_o=1 and held; cleared by spurious_clr_i. Core 2 state unchanged.
- Reset asserted while 2 cores are in WAIT → all outputs at reset values, no ack. With BARRIER_CLKGATE_EN, clk_en low only during WAIT.
